// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and defaults for the ALU command sequencer.
// Holds the ALU opcode enum, controller state enum and frame header constants.
package alu_cmd_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV,
        OP_AND, OP_OR, OP_NAND, OP_NOR,
        OP_XOR, OP_XNOR, OP_CMPEQ, OP_CMPGT,
        OP_CMPLT, OP_SHR, OP_SHL, OP_NOP
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_GET_FUN,
        S_RUN, S_WAIT, S_TX_LO, S_TX_HI
    } ctrl_state_e;

    localparam logic [7:0] CMD_OPER_DEF   = 8'hCC;
    localparam logic [7:0] CMD_NOOPER_DEF = 8'hDD;
    localparam int         TIMEOUT_DEF    = 15;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bundle of RX, ALU and TX signals around the command sequencer.
// master: sequencer side (drives ALU_*, TX_*, BUSY, ERR); slave: environment side.
interface alu_cmd_ctrl_if
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] RX_DATA;
    logic                  RX_VALID;
    logic [DATA_WIDTH-1:0] ALU_A;
    logic [DATA_WIDTH-1:0] ALU_B;
    alu_op_e               ALU_FUN;
    logic                  ALU_EN;
    logic [OUT_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VALID;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_VALID;
    logic                  TX_READY;
    logic                  BUSY;
    logic                  ERR;

    modport master (
        input  RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN,
        output TX_DATA, TX_VALID, BUSY, ERR
    );

    modport slave (
        output RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN,
        input  TX_DATA, TX_VALID, BUSY, ERR
    );

endinterface

// File: rtl/alu_cmd_ctrl_tx.sv
// ctrl_tx_serializer: holds a result word, emits low then high byte on valid/ready.
// Ports: CLK, RST (async low), load/word in, tx_ready in, tx_data/tx_valid out, lo_done/done out.
module ctrl_tx_serializer
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [OUT_WIDTH-1:0]  word,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  lo_done,
    output logic                  done
);
    // Low byte goes straight to tx_data on load; only the high byte is held.
    logic [DATA_WIDTH-1:0] hi_byte;
    logic                  hi_q;

    assign lo_done = tx_valid && tx_ready && !hi_q;
    assign done    = tx_valid && tx_ready && hi_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hi_byte  <= '0;
            hi_q     <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            hi_byte  <= word[OUT_WIDTH-1:DATA_WIDTH];
            tx_data  <= word[DATA_WIDTH-1:0];
            tx_valid <= 1'b1;
            hi_q     <= 1'b0;
        end else if (lo_done) begin
            tx_data  <= hi_byte;
            hi_q     <= 1'b1;
        end else if (done) begin
            tx_valid <= 1'b0;
            hi_q     <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer: parses CC/DD frames from RX, runs the ALU, returns result bytes to TX.
// Ports: CLK, RST (async low), bus (alu_cmd_ctrl_if.master: RX, ALU, TX, BUSY, ERR).
module alu_cmd_ctrl
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    OUT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_OPER    = CMD_OPER_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_NOOPER  = CMD_NOOPER_DEF,
    parameter int                    TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    alu_cmd_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    ctrl_state_e   state, state_n;
    logic [CW-1:0] cnt;
    logic          err_n;
    logic          a_ld, b_ld, fun_ld;
    logic          cnt_clr, cnt_inc;
    logic          load, lo_done, done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bus.ALU_A   <= '0;
            bus.ALU_B   <= '0;
            bus.ALU_FUN <= OP_ADD;
            bus.ALU_EN  <= 1'b0;
            bus.BUSY    <= 1'b0;
            bus.ERR     <= 1'b0;
        end else begin
            state <= state_n;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
            if (a_ld)
                bus.ALU_A <= bus.RX_DATA;
            if (b_ld)
                bus.ALU_B <= bus.RX_DATA;
            if (fun_ld)
                bus.ALU_FUN <= alu_op_e'(bus.RX_DATA[3:0]);
            // Outputs registered from next state so they line up with it.
            bus.ALU_EN <= (state_n == S_RUN);
            bus.BUSY   <= (state_n != S_IDLE);
            bus.ERR    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        a_ld    = 1'b0;
        b_ld    = 1'b0;
        fun_ld  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        load    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.RX_VALID) begin
                    if (bus.RX_DATA == CMD_OPER)
                        state_n = S_GET_A;
                    else if (bus.RX_DATA == CMD_NOOPER)
                        state_n = S_GET_FUN;
                    else
                        err_n = 1'b1;
                end
            end
            S_GET_A: begin
                if (bus.RX_VALID) begin
                    a_ld    = 1'b1;
                    state_n = S_GET_B;
                end
            end
            S_GET_B: begin
                if (bus.RX_VALID) begin
                    b_ld    = 1'b1;
                    state_n = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (bus.RX_VALID) begin
                    if (bus.RX_DATA[DATA_WIDTH-1:4] != '0) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        fun_ld  = 1'b1;
                        state_n = S_RUN;
                    end
                end
            end
            S_RUN: begin
                err_n   = bus.RX_VALID;
                cnt_clr = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // RX drop and timeout share one ERR pulse.
                err_n = bus.RX_VALID;
                if (bus.ALU_OUT_VALID) begin
                    load    = 1'b1;
                    state_n = S_TX_LO;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_TX_LO: begin
                err_n = bus.RX_VALID;
                if (lo_done)
                    state_n = S_TX_HI;
            end
            S_TX_HI: begin
                err_n = bus.RX_VALID;
                if (done)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    ctrl_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_tx (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .word     (bus.ALU_OUT),
        .tx_ready (bus.TX_READY),
        .tx_data  (bus.TX_DATA),
        .tx_valid (bus.TX_VALID),
        .lo_done  (lo_done),
        .done     (done)
    );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a one-cycle-latency ALU stub.
// Ports: none; drives the bus interface and checks frames, TX bytes, ERR and reset.
module tb_alu_cmd_ctrl;
    import alu_cmd_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   failures = 0;

    alu_cmd_ctrl_if #(.DATA_WIDTH(8), .OUT_WIDTH(16)) bus ();

    alu_cmd_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    // ALU stub: sees ALU_EN mid-cycle, answers with valid one cycle later.
    logic        alu_on = 1'b1;
    logic        en_seen = 1'b0;
    logic [15:0] res_seen = '0;

    always @(negedge CLK) begin
        en_seen = bus.ALU_EN;
        case (bus.ALU_FUN)
            OP_ADD:  res_seen = {8'h00, bus.ALU_A} + {8'h00, bus.ALU_B};
            OP_SUB:  res_seen = {8'h00, bus.ALU_A} - {8'h00, bus.ALU_B};
            OP_MUL:  res_seen = bus.ALU_A * bus.ALU_B;
            default: res_seen = '0;
        endcase
    end

    always @(posedge CLK) begin
        #1;
        bus.ALU_OUT_VALID = en_seen && alu_on;
        bus.ALU_OUT       = res_seen;
    end

    // Monitor: bytes accepted, ALU_EN and ERR pulses.
    logic [7:0] txq[$];
    int         en_cnt = 0;
    int         err_cnt = 0;

    always @(negedge CLK) begin
        if (bus.TX_VALID && bus.TX_READY)
            txq.push_back(bus.TX_DATA);
        if (bus.ALU_EN)
            en_cnt++;
        if (bus.ERR)
            err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        tick();
        bus.RX_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.BUSY || bus.TX_VALID) && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {30'd0, bus.BUSY, bus.TX_VALID}, 32'd0);
        tick();
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] lo,
                             input logic [7:0] hi);
        logic [7:0] b0, b1;
        b0 = (txq.size() > 0) ? txq[0] : 8'hxx;
        b1 = (txq.size() > 1) ? txq[1] : 8'hxx;
        chk({tag, "_n"}, txq.size(), 2);
        chk({tag, "_b"}, {16'd0, b1, b0}, {16'd0, hi, lo});
        txq.delete();
    endtask

    function automatic logic [31:0] outs();
        return {bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_EN,
                bus.TX_VALID, bus.BUSY, bus.ERR};
    endfunction

    initial begin
        int n;
        bus.RX_DATA       = '0;
        bus.RX_VALID      = 1'b0;
        bus.TX_READY      = 1'b1;
        bus.ALU_OUT       = '0;
        bus.ALU_OUT_VALID = 1'b0;

        // Reset state
        #3;
        chk("rst_outs", outs(), 32'd0);
        chk("rst_txd", bus.TX_DATA, 8'h00);
        tick();
        tick();
        RST = 1'b1;
        tick();
        txq.delete();
        en_cnt  = 0;
        err_cnt = 0;

        // 1: ADD 05+03
        send(8'hCC);
        send(8'h05);
        send(8'h03);
        send(8'h00);
        chk("t1_run", {bus.ALU_EN, bus.ALU_A, bus.ALU_B, 4'(bus.ALU_FUN)},
            {1'b1, 8'h05, 8'h03, 4'h0});
        tick();
        chk("t1_en_off", {bus.ALU_EN, bus.TX_VALID}, 2'b00);
        tick();
        chk("t1_first_tx", {bus.TX_VALID, bus.TX_DATA}, {1'b1, 8'h08});
        wait_idle("t1_idle");
        chk_bytes("t1", 8'h08, 8'h00);
        chk("t1_en_cnt", en_cnt, 1);
        chk("t1_err_cnt", err_cnt, 0);

        // 2: MUL FF*FF, then DD reuse with SUB
        send(8'hCC);
        send(8'hFF);
        send(8'hFF);
        send(8'h02);
        wait_idle("t2a_idle");
        chk_bytes("t2a", 8'h01, 8'hFE);
        send(8'hDD);
        send(8'h01);
        chk("t2b_run", {bus.ALU_EN, bus.ALU_A, bus.ALU_B, 4'(bus.ALU_FUN)},
            {1'b1, 8'hFF, 8'hFF, 4'h1});
        wait_idle("t2b_idle");
        chk_bytes("t2b", 8'h00, 8'h00);

        // 3: backpressure in TX_LO
        bus.TX_READY = 1'b0;
        send(8'hCC);
        send(8'h12);
        send(8'h34);
        send(8'h00);
        n = 0;
        while (!bus.TX_VALID && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold", {bus.TX_VALID, bus.TX_DATA}, {1'b1, 8'h46});
            tick();
        end
        bus.TX_READY = 1'b1;
        wait_idle("t3_idle");
        chk_bytes("t3", 8'h46, 8'h00);

        // 4: bad opcode, then bad header
        en_cnt = 0;
        send(8'hCC);
        send(8'h10);
        send(8'h20);
        send(8'h1F);
        chk("t4_badfun", {bus.ERR, bus.BUSY, bus.ALU_EN}, 3'b100);
        chk("t4_ops", {bus.ALU_A, bus.ALU_B}, {8'h10, 8'h20});
        tick();
        chk("t4_err_off", {bus.ERR, bus.BUSY}, 2'b00);
        send(8'h55);
        chk("t4_badhdr", {bus.ERR, bus.BUSY}, 2'b10);
        tick();
        chk("t4_no_en", en_cnt, 0);

        // 5: ALU never answers -> timeout
        alu_on = 1'b0;
        txq.delete();
        send(8'hCC);
        send(8'h07);
        send(8'h08);
        send(8'h00);
        n = 0;
        while (!bus.ERR && n < 40) begin
            tick();
            n++;
        end
        chk("t5_to_cyc", n, 16);
        chk("t5_to_state", {bus.BUSY, bus.TX_VALID}, 2'b00);
        tick();
        chk("t5_no_tx", txq.size(), 0);
        alu_on = 1'b1;
        send(8'hCC);
        send(8'h09);
        send(8'h03);
        send(8'h01);
        wait_idle("t5_idle");
        chk_bytes("t5", 8'h06, 8'h00);

        // 6a: reset in WAIT
        alu_on = 1'b0;
        send(8'hCC);
        send(8'h01);
        send(8'h01);
        send(8'h00);
        tick();
        RST = 1'b0;
        #1;
        chk("t6_rst_wait", outs(), 32'd0);
        tick();
        RST = 1'b1;
        alu_on = 1'b1;
        tick();

        // 6b: reset in TX_HI
        send(8'hCC);
        send(8'h03);
        send(8'h04);
        send(8'h00);
        tick();
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("t6_rst_txhi", outs(), 32'd0);
        chk("t6_rst_txd", bus.TX_DATA, 8'h00);
        tick();
        RST = 1'b1;
        tick();
        chk("t6_rst_bytes", txq.size(), 1);
        txq.delete();

        // stored operands are 0 after reset
        send(8'hDD);
        send(8'h00);
        wait_idle("t6_dd_idle");
        chk_bytes("t6_dd", 8'h00, 8'h00);

        // 6c: RX during TX -> ERR, frame intact
        bus.TX_READY = 1'b0;
        send(8'hCC);
        send(8'h04);
        send(8'h05);
        send(8'h00);
        tick();
        tick();
        send(8'h77);
        chk("t6_rx_drop", {bus.ERR, bus.TX_VALID, bus.TX_DATA},
            {1'b1, 1'b1, 8'h09});
        bus.TX_READY = 1'b1;
        wait_idle("t6_idle");
        chk_bytes("t6_drop", 8'h09, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
